// File: rtl/reg_bank_pkg.sv
// Shared default sizes and handy typedefs for the register bank with lock scoreboard.
package reg_bank_pkg;

  localparam int REG_BANK_NUM_REGS = 16;
  localparam int REG_BANK_DATA_W   = 32;
  localparam int REG_BANK_NUM_RD   = 2;
  localparam int REG_BANK_ADDR_W   = $clog2(REG_BANK_NUM_REGS);

  typedef logic [REG_BANK_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_BANK_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_bank_rd_port.sv
// One read port: grant against the scoreboard, write-to-read bypass and the
// registered rd_valid/rd_data result.
module reg_bank_rd_port #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              reg_locked,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);

  logic bypass;
  logic accept;

  // wr_en arrives already qualified, so bypass never forwards a write the bank ignores
  assign bypass = wr_en && (wr_addr == rd_addr);
  assign rd_gnt = !reg_locked || bypass;
  assign accept = rd_req && rd_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= accept;
      if (accept) begin
        rd_data <= bypass ? wr_data : reg_data;
      end
    end
  end

endmodule

// File: rtl/reg_bank_scb.sv
// Register bank with NUM_RD registered read ports, write bypass and a lock scoreboard.
// Define REG_BANK_R0_ZERO_EN to hard-wire register 0 to zero (never written, never locked).
module reg_bank_scb
  import reg_bank_pkg::*;
#(
  parameter int NUM_REGS = REG_BANK_NUM_REGS,
  parameter int DATA_W   = REG_BANK_DATA_W,
  parameter int NUM_RD   = REG_BANK_NUM_RD,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     lock_en,
  input  logic [ADDR_W-1:0]        lock_addr,
  input  logic [NUM_RD-1:0]        rd_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_gnt,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_REGS-1:0]      locked
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_ok;
  logic              lock_ok;

`ifdef REG_BANK_R0_ZERO_EN
  assign wr_ok   = wr_en && (int'(wr_addr) < NUM_REGS) && (wr_addr != '0);
  assign lock_ok = lock_en && (int'(lock_addr) < NUM_REGS) && (lock_addr != '0);
`else
  assign wr_ok   = wr_en && (int'(wr_addr) < NUM_REGS);
  assign lock_ok = lock_en && (int'(lock_addr) < NUM_REGS);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Lock is applied after the write clear so a new writer's lock survives a same-cycle write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked <= '0;
    end else begin
      if (wr_ok) begin
        locked[wr_addr] <= 1'b0;
      end
      if (lock_ok) begin
        locked[lock_addr] <= 1'b1;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;
    logic              lk;

    assign addr = rd_addr[p*ADDR_W +: ADDR_W];

    // Out-of-range indices look like an unlocked register holding zero
    always_comb begin
      val = '0;
      lk  = 1'b0;
      if (int'(addr) < NUM_REGS) begin
        val = regs[addr];
        lk  = locked[addr];
      end
    end

    reg_bank_rd_port #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_rd_port (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_req     (rd_req[p]),
      .rd_addr    (addr),
      .wr_en      (wr_ok),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .reg_data   (val),
      .reg_locked (lk),
      .rd_gnt     (rd_gnt[p]),
      .rd_valid   (rd_valid[p]),
      .rd_data    (rd_data[p*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_reg_bank_scb.sv
// Directed bench for reg_bank_scb at default sizes; covers the REG_BANK_R0_ZERO_EN build too.
module tb_reg_bank_scb;
  import reg_bank_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  reg_addr_t   wr_addr;
  reg_data_t   wr_data;
  logic        lock_en;
  reg_addr_t   lock_addr;
  logic [1:0]  rd_req;
  logic [7:0]  rd_addr;
  logic [1:0]  rd_gnt;
  logic [1:0]  rd_valid;
  logic [63:0] rd_data;
  logic [15:0] locked;

  int n_checks;
  int n_fail;

  reg_bank_scb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .lock_en   (lock_en),
    .lock_addr (lock_addr),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a full input vector at the falling edge, then let grant settle
  task automatic apply_stimulus(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                                input logic le, input logic [3:0] la, input logic [1:0] rq,
                                input logic [3:0] a0, input logic [3:0] a1);
    @(negedge clk);
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    lock_en   = le;
    lock_addr = la;
    rd_req    = rq;
    rd_addr   = {a1, a0};
    #1;
  endtask

  task automatic clock_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    lock_en   = 1'b0;
    lock_addr = '0;
    rd_req    = '0;
    rd_addr   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_valid", 64'(rd_valid), 64'h0);
    check_output("reset_data", rd_data, 64'h0);
    check_output("reset_locked", 64'(locked), 64'h0);
    check_output("reset_gnt", 64'(rd_gnt), 64'h3);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write then read
    apply_stimulus(1, 4'd5, 32'hDEADBEEF, 0, 0, 2'b00, 0, 0);
    clock_edge();
    apply_stimulus(0, 0, 0, 0, 0, 2'b01, 4'd5, 0);
    check_output("basic_gnt", 64'(rd_gnt[0]), 64'h1);
    clock_edge();
    check_output("basic_valid", 64'(rd_valid), 64'h1);
    check_output("basic_data0", 64'(rd_data[31:0]), 64'hDEADBEEF);

    // Bypass on port 1
    apply_stimulus(1, 4'd3, 32'h12345678, 0, 0, 2'b10, 0, 4'd3);
    check_output("bypass_gnt", 64'(rd_gnt[1]), 64'h1);
    clock_edge();
    check_output("bypass_valid", 64'(rd_valid), 64'h2);
    check_output("bypass_data1", 64'(rd_data[63:32]), 64'h12345678);
    check_output("hold_data0", 64'(rd_data[31:0]), 64'hDEADBEEF);

    // Scoreboard stall on r7
    apply_stimulus(0, 0, 0, 1, 4'd7, 2'b00, 0, 0);
    clock_edge();
    check_output("lock7_locked", 64'(locked), 64'h0080);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 0, 0, 0, 2'b01, 4'd7, 0);
      check_output("stall7_gnt", 64'(rd_gnt[0]), 64'h0);
      clock_edge();
      check_output("stall7_valid", 64'(rd_valid), 64'h0);
    end
    apply_stimulus(1, 4'd7, 32'hA5A5A5A5, 0, 0, 2'b01, 4'd7, 0);
    check_output("wake7_gnt", 64'(rd_gnt[0]), 64'h1);
    clock_edge();
    check_output("wake7_valid", 64'(rd_valid), 64'h1);
    check_output("wake7_data0", 64'(rd_data[31:0]), 64'hA5A5A5A5);
    check_output("wake7_locked", 64'(locked), 64'h0);

    // Simultaneous lock and write on r9: lock survives
    apply_stimulus(1, 4'd9, 32'h1, 1, 4'd9, 2'b00, 0, 0);
    clock_edge();
    check_output("lw9_locked", 64'(locked), 64'h0200);
    apply_stimulus(0, 0, 0, 0, 0, 2'b01, 4'd9, 0);
    check_output("lw9_stall_gnt", 64'(rd_gnt[0]), 64'h0);
    clock_edge();
    check_output("lw9_stall_valid", 64'(rd_valid), 64'h0);
    apply_stimulus(1, 4'd9, 32'h55, 0, 0, 2'b01, 4'd9, 0);
    check_output("lw9_wake_gnt", 64'(rd_gnt[0]), 64'h1);
    clock_edge();
    check_output("lw9_wake_data0", 64'(rd_data[31:0]), 64'h55);
    check_output("lw9_wake_locked", 64'(locked), 64'h0);

    // Lock in the same cycle as a read sees the pre-edge (unlocked) state
    apply_stimulus(0, 0, 0, 1, 4'd4, 2'b01, 4'd4, 0);
    check_output("lockrd_gnt", 64'(rd_gnt[0]), 64'h1);
    clock_edge();
    check_output("lockrd_valid", 64'(rd_valid), 64'h1);
    check_output("lockrd_data0", 64'(rd_data[31:0]), 64'h0);
    check_output("lockrd_locked", 64'(locked), 64'h0010);

    // Both ports read r5
    apply_stimulus(0, 0, 0, 0, 0, 2'b11, 4'd5, 4'd5);
    check_output("dual_gnt", 64'(rd_gnt), 64'h3);
    clock_edge();
    check_output("dual_valid", 64'(rd_valid), 64'h3);
    check_output("dual_data", rd_data, 64'hDEADBEEF_DEADBEEF);

    // Async reset mid-cycle drops the in-flight read state
    #2;
    rst_n = 1'b0;
    #1;
    check_output("areset_valid", 64'(rd_valid), 64'h0);
    check_output("areset_data", rd_data, 64'h0);
    check_output("areset_locked", 64'(locked), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0, 2'b01, 4'd5, 0);
    clock_edge();
    check_output("post_reset_valid", 64'(rd_valid), 64'h1);
    check_output("post_reset_data0", 64'(rd_data[31:0]), 64'h0);

`ifdef REG_BANK_R0_ZERO_EN
    apply_stimulus(1, 4'd0, 32'hFFFFFFFF, 0, 0, 2'b00, 0, 0);
    clock_edge();
    apply_stimulus(0, 0, 0, 1, 4'd0, 2'b00, 0, 0);
    clock_edge();
    check_output("r0_locked", 64'(locked), 64'h0);
    apply_stimulus(1, 4'd0, 32'hFFFFFFFF, 0, 0, 2'b01, 4'd0, 0);
    check_output("r0_gnt", 64'(rd_gnt[0]), 64'h1);
    clock_edge();
    check_output("r0_valid", 64'(rd_valid), 64'h1);
    check_output("r0_data0", 64'(rd_data[31:0]), 64'h0);
`else
    apply_stimulus(0, 0, 0, 1, 4'd0, 2'b00, 0, 0);
    clock_edge();
    check_output("r0_locked", 64'(locked), 64'h1);
    apply_stimulus(0, 0, 0, 0, 0, 2'b01, 4'd0, 0);
    check_output("r0_stall_gnt", 64'(rd_gnt[0]), 64'h0);
    clock_edge();
    check_output("r0_stall_valid", 64'(rd_valid), 64'h0);
    apply_stimulus(1, 4'd0, 32'hCAFEF00D, 0, 0, 2'b01, 4'd0, 0);
    check_output("r0_wake_gnt", 64'(rd_gnt[0]), 64'h1);
    clock_edge();
    check_output("r0_wake_data0", 64'(rd_data[31:0]), 64'hCAFEF00D);
`endif

    apply_stimulus(0, 0, 0, 0, 0, 2'b00, 0, 0);
    clock_edge();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
